// File: rtl/dac_feed_ctrl.sv
// dac_feed_ctrl: write-side controller for the 2 KiB DAC sample buffer.
// Arbitrates single-byte writes from the MCU program port and the MSU audio
// stream onto the buffer's one write port. It also tracks the stream fill
// level against the DAC word play address.
// Optional feature: define DAC_FEED_UNDERRUN_EN to build the sticky underrun
// detector. Without it, underrun is tied low.
module dac_feed_ctrl #(
  parameter int unsigned REFILL_WORDS = 256
) (
  input  logic        clkin,
  input  logic        reset_n,
  input  logic        mcu_req,
  input  logic [10:0] mcu_addr,
  input  logic [7:0]  mcu_data,
  output logic        mcu_ack,
  input  logic        msu_req,
  input  logic [7:0]  msu_data,
  output logic        msu_ack,
  input  logic        msu_enable,
  input  logic        ctl_restart,
  input  logic [8:0]  dac_address,
  input  logic        play,
  output logic        buf_we_n,
  output logic [10:0] buf_addr,
  output logic [7:0]  buf_data,
  output logic [10:0] wr_ptr,
  output logic        refill_req,
  output logic        buf_full,
  output logic        underrun
);

  // The threshold is compared against a 9-bit word level. Ten bits let a
  // threshold of 512 mean "always request refill".
  localparam logic [9:0] REFILL_THRESH = 10'(REFILL_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  typedef enum logic {
    GNT_MSU = 1'b0,
    GNT_MCU = 1'b1
  } grant_e;

  state_e      state_q, state_d;
  grant_e      grant_q, grant_d;
  grant_e      last_grant_q, last_grant_d;
  logic [10:0] buf_addr_q, buf_addr_d;
  logic [7:0]  buf_data_q, buf_data_d;
  logic [10:0] wr_ptr_q, wr_ptr_d;

  logic        mcu_elig;
  logic        msu_elig;
  logic        grant_valid;
  grant_e      grant_sel;

  logic [8:0]  lvl_words;
  logic [10:0] free_bytes;
  logic        full;

  // Stream level arithmetic. Everything is modular, so a pointer wrap needs no
  // special case.
  always_comb begin
    lvl_words  = wr_ptr_q[10:2] - dac_address;
    free_bytes = {dac_address, 2'b00} - wr_ptr_q - 11'd1;
  end

  assign full       = (free_bytes == 11'd0);
  assign buf_full   = full;
  assign refill_req = msu_enable & ({1'b0, lvl_words} < REFILL_THRESH);

  // Request eligibility and round-robin choice. On a tie, the requester that
  // did not win last time gets the grant.
  always_comb begin
    mcu_elig    = mcu_req;
    msu_elig    = msu_req & ~full;
    grant_valid = mcu_elig | msu_elig;
    grant_sel   = GNT_MSU;
    if (mcu_elig && msu_elig) begin
      grant_sel = (last_grant_q == GNT_MCU) ? GNT_MSU : GNT_MCU;
    end else if (mcu_elig) begin
      grant_sel = GNT_MCU;
    end
  end

  // State register.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each accepted request takes IDLE -> WR -> ACK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_valid) state_d = ST_WR;
      ST_WR:   state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode. The write strobe and the acks come straight from the state.
  // An async reset therefore drops them at once.
  always_comb begin
    buf_we_n = 1'b1;
    mcu_ack  = 1'b0;
    msu_ack  = 1'b0;
    case (state_q)
      ST_WR: buf_we_n = 1'b0;
      ST_ACK: begin
        if (grant_q == GNT_MCU) begin
          mcu_ack = 1'b1;
        end else begin
          msu_ack = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath next values: latch the grant, address and data in IDLE. The
  // stream pointer advances after an MSU write. A restart forces the pointer
  // to zero, even over that increment.
  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    wr_ptr_d     = wr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          grant_d = grant_sel;
          if (grant_sel == GNT_MCU) begin
            buf_addr_d = mcu_addr;
            buf_data_d = mcu_data;
          end else begin
            buf_addr_d = wr_ptr_q;
            buf_data_d = msu_data;
          end
        end
      end
      ST_WR: begin
        if (grant_q == GNT_MSU) begin
          wr_ptr_d = wr_ptr_q + 11'd1;
        end
      end
      ST_ACK: last_grant_d = grant_q;
      default: ;
    endcase
    if (ctl_restart) begin
      wr_ptr_d = 11'd0;
    end
  end

  // Datapath registers. The last grant resets to MSU, so the MCU wins the
  // first tie.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      grant_q      <= GNT_MSU;
      last_grant_q <= GNT_MSU;
      buf_addr_q   <= 11'd0;
      buf_data_q   <= 8'd0;
      wr_ptr_q     <= 11'd0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  assign buf_addr = buf_addr_q;
  assign buf_data = buf_data_q;
  assign wr_ptr   = wr_ptr_q;

`ifdef DAC_FEED_UNDERRUN_EN
  logic underrun_q, underrun_d;

  // Sticky underrun: set when the DAC plays an empty stream. Only a restart
  // clears it, and a restart wins over a set in the same cycle.
  always_comb begin
    underrun_d = underrun_q;
    if (ctl_restart) begin
      underrun_d = 1'b0;
    end else if (play && msu_enable && (lvl_words == 9'd0)) begin
      underrun_d = 1'b1;
    end
  end

  // Underrun flag register.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  assign underrun = underrun_q;
`else
  logic unused_play;

  assign underrun    = 1'b0;
  assign unused_play = play;
`endif

  ack_onehot_a: assert property (@(posedge clkin) disable iff (!reset_n)
    !(mcu_ack && msu_ack));

endmodule
